// File: rtl/ori_bin_cordic.sv
// Iterative CORDIC gradient-orientation quantizer: (dx, dy) -> 5-bit bin (32 over 360 deg) + magnitude.
// Define ORI_BIN_GAIN_COMP_EN to scale the magnitude by ~1/1.647 (CORDIC gain compensation).
module ori_bin_cordic #(
  parameter int IN_W = 9,
  parameter int ITER = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] dx,
  input  logic signed [IN_W-1:0] dy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             bin,
  output logic [IN_W+1:0]        mag
);

  localparam int W = IN_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ROT,
    S_POST,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic signed [W-1:0] x, y;
  logic signed [W-1:0] x_sh, y_sh;
  logic [W-1:0]        x_mag;
  logic [W-1:0]        mag_nxt;
  logic [15:0]         ang;
  logic [3:0]          iter;
  logic                zero;
  logic                last_iter;
  logic                accept;
  logic [4:0]          bin_nxt;

  // atan(2^-k) scaled so that 65536 is a full turn.
  function automatic logic [15:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    atan_lut = 16'd8192;
      4'd1:    atan_lut = 16'd4836;
      4'd2:    atan_lut = 16'd2555;
      4'd3:    atan_lut = 16'd1297;
      4'd4:    atan_lut = 16'd651;
      4'd5:    atan_lut = 16'd326;
      4'd6:    atan_lut = 16'd163;
      4'd7:    atan_lut = 16'd81;
      4'd8:    atan_lut = 16'd41;
      4'd9:    atan_lut = 16'd20;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  assign last_iter = (iter == 4'(ITER - 1));
  assign accept    = (state == S_IDLE) && in_valid && in_ready;
  assign out_valid = (state == S_OUT);

  assign x_sh  = x >>> iter;
  assign y_sh  = y >>> iter;
  assign x_mag = $unsigned(x);

  // Round to nearest bin; the 16-bit add wraps a near-360 angle back to bin 0.
  assign bin_nxt = 5'((ang + 16'd1024) >> 11);

`ifdef ORI_BIN_GAIN_COMP_EN
  assign mag_nxt = (x_mag >> 1) + (x_mag >> 3) - (x_mag >> 6) - (x_mag >> 9);
`else
  assign mag_nxt = x_mag;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid && in_ready) state_nxt = S_PRE;
      S_PRE:  state_nxt = S_ROT;
      S_ROT:  if (last_iter) state_nxt = S_POST;
      S_POST: state_nxt = S_OUT;
      S_OUT:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered so in_ready stays low through reset and rises the cycle after release.
  always_ff @(posedge clk) begin
    if (!rst_n) in_ready <= 1'b0;
    else        in_ready <= (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      ang  <= '0;
      iter <= '0;
      zero <= 1'b0;
      bin  <= '0;
      mag  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            x    <= {{2{dx[IN_W-1]}}, dx};
            y    <= {{2{dy[IN_W-1]}}, dy};
            zero <= (dx == '0) && (dy == '0);
          end
        end
        S_PRE: begin
          // Fold the left half-plane onto the right so the rotations converge.
          if (x[W-1]) begin
            x   <= -x;
            y   <= -y;
            ang <= 16'h8000;
          end else begin
            ang <= 16'h0000;
          end
          iter <= '0;
        end
        S_ROT: begin
          if (!y[W-1]) begin
            x   <= x + y_sh;
            y   <= y - x_sh;
            ang <= ang + atan_lut(iter);
          end else begin
            x   <= x - y_sh;
            y   <= y + x_sh;
            ang <= ang - atan_lut(iter);
          end
          iter <= iter + 4'd1;
        end
        S_POST: begin
          if (zero) begin
            bin <= '0;
            mag <= '0;
          end else begin
            bin <= bin_nxt;
            mag <= mag_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
